// File: rtl/ticket_pkg.sv
// Shared widths, number range, FSM encoding and LFSR taps for the ticket/queue/counter path.
// Number 0 is reserved downstream as "empty", so valid numbers run NUM_MIN..NUM_MAX.
package ticket_pkg;

    localparam int NUM_W  = 4;
    localparam int TIME_W = 4;

    localparam logic [NUM_W-1:0]  NUM_MIN  = 4'd1;
    localparam logic [NUM_W-1:0]  NUM_MAX  = 4'd15;
    localparam logic [TIME_W-1:0] TIME_MAX = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, bit 7 is tap 8
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [TIME_W-1:0] map_time(
        input logic       man_en,
        input logic [2:0] man_time,
        input logic [2:0] rnd
    );
        logic [2:0] t;
        if (man_en)
            t = (man_time == 3'd0) ? 3'd1 : man_time;
        else
            t = (rnd == 3'd0) ? 3'd4 : rnd;
        return {1'b0, t};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchronizer + level debounce + rising-edge press pulse for a front-panel button.
// Latency: press fires 2 + DB_CYCLES cycles after a clean rising input.
// Backpressure: none; press is a fire-and-forget single-cycle pulse.
module btn_debounce #(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 16'd1);

    logic [1:0]       sync;
    logic             btn_s;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    assign btn_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b00;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            // any disagreeing sample restarts the qualification window
            if (btn_s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= btn_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/ticket_gen.sv
// Purpose: turn a debounced button press into a {number, service time} customer record.
// Latency: out_valid one cycle after the press pulse; deferred while stall is high.
// Backpressure: stall holds one pending request; further presses while pending are dropped.
module ticket_gen
    import ticket_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              stall,
    input  logic              man_en,
    input  logic [2:0]        man_time,
    output logic              out_valid,
    output logic [NUM_W-1:0]  out_num,
    output logic [TIME_W-1:0] out_time,
    output logic              pending,
    output logic              drop
);

    logic              req;
    logic              issue;
    state_t            state;
    logic [NUM_W-1:0]  next_num;
    logic [NUM_W-1:0]  num_inc;
    logic [TIME_W-1:0] time_sel;
    logic [7:0]        lfsr;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (req)
    );

    // free-running so the drawn time depends on when the customer arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    always_comb begin
        time_sel = map_time(man_en, man_time, lfsr[2:0]);
        num_inc  = (next_num == NUM_MAX) ? NUM_MIN : next_num + 1'b1;
        issue    = !stall && ((state == ST_WAIT) || req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            next_num  <= NUM_MIN;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_time  <= '0;
            pending   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            out_valid <= issue;
            drop      <= (state == ST_WAIT) && req;
            if (issue) begin
                out_num  <= next_num;
                out_time <= time_sel;
                next_num <= num_inc;
            end
            case (state)
                ST_IDLE: begin
                    if (req && stall) begin
                        state   <= ST_WAIT;
                        pending <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!stall) begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ticket_gen.sv
// Directed bench for ticket_gen with a 4-cycle debounce and a reference LFSR.
module tb_ticket_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       stall;
    logic       man_en;
    logic [2:0] man_time;
    logic       out_valid;
    logic [3:0] out_num;
    logic [3:0] out_time;
    logic       pending;
    logic       drop;

    always #5 clk = ~clk;

    ticket_gen #(
        .DB_CYCLES (16'd4),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .stall     (stall),
        .man_en    (man_en),
        .man_time  (man_time),
        .out_valid (out_valid),
        .out_num   (out_num),
        .out_time  (out_time),
        .pending   (pending),
        .drop      (drop)
    );

    int n_vec = 0;
    int n_err = 0;

    int         win_str;
    int         win_drop;
    int         win_at;
    int         win_i;
    logic [3:0] cap_num;
    logic [3:0] cap_time;
    logic [3:0] cap_exp;

    // reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic logic [3:0] ref_time(input logic men, input logic [2:0] mt,
                                            input logic [7:0] l);
        if (men)
            return (mt == 3'd0) ? 4'd1 : {1'b0, mt};
        return (l[2:0] == 3'd0) ? 4'd4 : {1'b0, l[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_win();
        win_str  = 0;
        win_drop = 0;
        win_at   = 0;
        win_i    = 0;
    endtask

    task automatic step();
        @(negedge clk);
        win_i++;
        if (out_valid) begin
            win_str++;
            if (win_at == 0) win_at = win_i;
            cap_num  = out_num;
            cap_time = out_time;
            cap_exp  = ref_time(man_en, man_time, m_prev);
        end
        if (drop) win_drop++;
    endtask

    task automatic hold(input logic b, input int n);
        btn = b;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_release();
        hold(1'b1, 10);
        hold(1'b0, 10);
    endtask

    initial begin
        rst      = 1'b1;
        btn      = 1'b0;
        stall    = 1'b0;
        man_en   = 1'b1;
        man_time = 3'd3;
        cap_num  = '0;
        cap_time = '0;
        cap_exp  = '0;
        clear_win();

        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_num",   out_num,   0);
        chk("rst_time",  out_time,  0);
        chk("rst_pend",  pending,   0);
        chk("rst_drop",  drop,      0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: clean press, manual time 3
        clear_win();
        hold(1'b1, 10);
        chk("t1_count",   win_str, 1);
        chk("t1_latency", win_at,  7);
        chk("t1_num",     cap_num, 1);
        chk("t1_time",    cap_time, 3);
        clear_win();
        hold(1'b0, 10);
        chk("t1_release", win_str, 0);

        // 2: bounce shorter than the debounce window
        clear_win();
        for (int k = 0; k < 5; k++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        chk("t2_bounce", win_str, 0);
        clear_win();
        hold(1'b1, 10);
        chk("t2_count", win_str, 1);
        chk("t2_num",   cap_num, 2);
        clear_win();
        hold(1'b0, 10);
        chk("t2_release", win_str, 0);

        // reset so numbering and LFSR restart
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t3_rst_num", out_num, 0);

        // 3: 16 LFSR-timed presses, numbers wrap 15 -> 1
        man_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            clear_win();
            press_release();
            chk("t3_count", win_str, 1);
            chk("t3_num",   cap_num, (k % 15) + 1);
            chk("t3_time",  cap_time, cap_exp);
            chk("t3_range", (cap_time >= 4'd1) && (cap_time <= 4'd7), 1);
        end

        // 4: stall, pending, drop, then release of stall
        man_en   = 1'b1;
        man_time = 3'd5;
        stall    = 1'b1;
        clear_win();
        press_release();
        chk("t4_no_strobe", win_str, 0);
        chk("t4_pending",   pending, 1);
        clear_win();
        press_release();
        chk("t4_drop",       win_drop, 1);
        chk("t4_no_strobe2", win_str,  0);
        chk("t4_pending2",   pending,  1);
        clear_win();
        stall = 1'b0;
        step();
        chk("t4_issue",   win_str,  1);
        chk("t4_num",     cap_num,  2);
        chk("t4_time",    cap_time, 5);
        chk("t4_pend_clr", pending, 0);
        step();
        chk("t4_single", win_str, 1);

        // 5: manual time 0 coerced to 1
        man_time = 3'd0;
        clear_win();
        press_release();
        chk("t5_count", win_str,  1);
        chk("t5_num",   cap_num,  3);
        chk("t5_time",  cap_time, 1);

        // 6: async reset while a request is pending
        man_time = 3'd3;
        for (int k = 0; k < 4; k++) press_release();
        chk("t6_num7", cap_num, 7);
        stall = 1'b1;
        clear_win();
        press_release();
        chk("t6_pending", pending, 1);
        chk("t6_outnum",  out_num, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_num",   out_num,   0);
        chk("t6_rst_time",  out_time,  0);
        chk("t6_rst_pend",  pending,   0);
        chk("t6_rst_drop",  drop,      0);
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        clear_win();
        hold(1'b0, 10);
        chk("t6_quiet", win_str, 0);
        clear_win();
        press_release();
        chk("t6_count", win_str, 1);
        chk("t6_num",   cap_num, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
